// File: rtl/adat_rx_pkg.sv
// rtl/adat_rx_pkg.sv - shared constants, state type and group/channel helper for the ADAT receive sequencer
package adat_rx_pkg;

  localparam int ADAT_GROUPS   = 49;
  localparam int GROUP_BITS    = 5;
  localparam int MAX_BEAT_BITS = 5;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Group 0 carries the user nibble, so channel groups start at 1.
  function automatic logic [2:0] group_to_ch(input logic [5:0] g, input int nibbles_per_ch);
    int t;
    t = (int'(g) - 1) / nibbles_per_ch;
    return t[2:0];
  endfunction

endpackage

// File: rtl/adat_rx_beat_serializer.sv
// rtl/adat_rx_beat_serializer.sv - holds one decoder beat and drains it one bit per cycle, oldest first
module adat_rx_beat_serializer
  import adat_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [4:0] i_bits,
  input  logic [2:0] i_bit_count,
  input  logic       i_flush,
  output logic       o_bit_valid,
  output logic       o_bit,
  output logic       o_overrun
);

  logic [4:0] r_hold;
  logic [2:0] r_pending;
  logic       w_beat;
  logic       w_accept;

  assign w_beat      = i_load && (i_bit_count != 3'd0) && (i_bit_count <= 3'(MAX_BEAT_BITS));
  assign o_overrun   = w_beat && (r_pending >= 3'd2);
  assign w_accept    = w_beat && (r_pending <= 3'd1);
  assign o_bit_valid = (r_pending != 3'd0);
  assign o_bit       = r_hold[0];

  // A new beat may load in the same cycle the last pending bit is consumed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hold    <= 5'd0;
      r_pending <= 3'd0;
    end else if (i_flush || o_overrun) begin
      r_hold    <= 5'd0;
      r_pending <= 3'd0;
    end else if (w_accept) begin
      r_hold    <= i_bits;
      r_pending <= i_bit_count;
    end else if (r_pending != 3'd0) begin
      r_hold    <= {1'b0, r_hold[4:1]};
      r_pending <= r_pending - 3'd1;
    end
  end

endmodule

// File: rtl/adat_rx_frame_sequencer.sv
// rtl/adat_rx_frame_sequencer.sv - tracks the 49 post-sync groups of an ADAT frame, checks separators, emits user nibble and channel samples
module adat_rx_frame_sequencer
  import adat_rx_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int NIBBLES_PER_CH = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sync,
  input  logic                          i_valid,
  input  logic [4:0]                    i_bits,
  input  logic [2:0]                    i_bit_count,
  output logic                          o_sync_mask,
  output logic [3:0]                    o_user,
  output logic [4*NIBBLES_PER_CH-1:0]   o_sample,
  output logic [2:0]                    o_sample_ch,
  output logic                          o_sample_valid,
  output logic                          o_frame_done,
  output logic                          o_err_sep,
  output logic                          o_err_short,
  output logic                          o_err_overrun
);

  localparam int          SW         = 4 * NIBBLES_PER_CH;
  localparam logic [5:0]  LAST_GROUP = 6'(NUM_CH * NIBBLES_PER_CH);
  localparam logic [2:0]  NIB_LAST   = 3'(NIBBLES_PER_CH - 1);
  localparam logic [2:0]  SEP_POS    = 3'(GROUP_BITS - 1);

  state_t          r_state, w_state_nxt;
  logic [5:0]      r_group, w_group_nxt;
  logic [2:0]      r_bit_pos, w_bit_pos_nxt;
  logic [2:0]      r_nib, w_nib_nxt;
  logic [SW-1:0]   r_shift, w_shift_nxt;
  logic [3:0]      r_user_pend, w_user_pend_nxt;
  logic [3:0]      r_user, w_user_nxt;
  logic [SW-1:0]   r_sample, w_sample_nxt;
  logic [2:0]      r_sample_ch, w_sample_ch_nxt;
  logic            r_sync_mask;
  logic            r_sample_valid, w_sample_valid_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic            r_err_sep, w_err_sep_nxt;
  logic            r_err_short, w_err_short_nxt;
  logic            r_err_overrun, w_err_overrun_nxt;

  logic            w_load;
  logic            w_flush;
  logic            w_bit_valid;
  logic            w_bit;
  logic            w_overrun;
  logic            w_frame_end;
  logic            w_take;

  assign w_load = i_valid && (r_state == ST_RUN) && !i_sync;

  adat_rx_beat_serializer u_ser (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_bits      (i_bits),
    .i_bit_count (i_bit_count),
    .i_flush     (w_flush),
    .o_bit_valid (w_bit_valid),
    .o_bit       (w_bit),
    .o_overrun   (w_overrun)
  );

  assign w_frame_end = (r_state == ST_RUN) && !w_overrun && w_bit_valid &&
                       (r_bit_pos == SEP_POS) && w_bit && (r_group == LAST_GROUP);
  // A sync discards the bit in flight unless that bit completes the frame.
  assign w_take = (r_state == ST_RUN) && w_bit_valid && !w_overrun && (!i_sync || w_frame_end);

  always_comb begin
    w_state_nxt        = r_state;
    w_group_nxt        = r_group;
    w_bit_pos_nxt      = r_bit_pos;
    w_nib_nxt          = r_nib;
    w_shift_nxt        = r_shift;
    w_user_pend_nxt    = r_user_pend;
    w_user_nxt         = r_user;
    w_sample_nxt       = r_sample;
    w_sample_ch_nxt    = r_sample_ch;
    w_sample_valid_nxt = 1'b0;
    w_frame_done_nxt   = 1'b0;
    w_err_sep_nxt      = 1'b0;
    w_err_short_nxt    = 1'b0;
    w_err_overrun_nxt  = 1'b0;
    w_flush            = 1'b0;

    if ((r_state == ST_RUN) && w_overrun) begin
      w_err_overrun_nxt = 1'b1;
      w_state_nxt       = ST_HUNT;
    end

    if (w_take) begin
      if (r_bit_pos != SEP_POS) begin
        w_shift_nxt   = {r_shift[SW-2:0], w_bit};
        w_bit_pos_nxt = r_bit_pos + 3'd1;
      end else if (!w_bit) begin
        w_err_sep_nxt = 1'b1;
        w_state_nxt   = ST_HUNT;
        w_flush       = 1'b1;
      end else begin
        w_bit_pos_nxt = 3'd0;
        if (r_group == 6'd0) begin
          w_user_pend_nxt = r_shift[3:0];
        end else if (r_nib == NIB_LAST) begin
          w_sample_valid_nxt = 1'b1;
          w_sample_nxt       = r_shift;
          w_sample_ch_nxt    = group_to_ch(r_group, NIBBLES_PER_CH);
          w_nib_nxt          = 3'd0;
        end else begin
          w_nib_nxt = r_nib + 3'd1;
        end
        if (w_frame_end) begin
          w_frame_done_nxt = 1'b1;
          w_user_nxt       = r_user_pend;
          w_state_nxt      = ST_HUNT;
          w_flush          = 1'b1;
        end else begin
          w_group_nxt = r_group + 6'd1;
        end
      end
    end

    if (i_sync) begin
      if ((r_state == ST_RUN) && !w_frame_end) w_err_short_nxt = 1'b1;
      w_state_nxt   = ST_RUN;
      w_group_nxt   = 6'd0;
      w_bit_pos_nxt = 3'd0;
      w_nib_nxt     = 3'd0;
      w_shift_nxt   = '0;
      w_flush       = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= ST_HUNT;
      r_group        <= 6'd0;
      r_bit_pos      <= 3'd0;
      r_nib          <= 3'd0;
      r_shift        <= '0;
      r_user_pend    <= 4'd0;
      r_user         <= 4'd0;
      r_sample       <= '0;
      r_sample_ch    <= 3'd0;
      r_sync_mask    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_sep      <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_group        <= w_group_nxt;
      r_bit_pos      <= w_bit_pos_nxt;
      r_nib          <= w_nib_nxt;
      r_shift        <= w_shift_nxt;
      r_user_pend    <= w_user_pend_nxt;
      r_user         <= w_user_nxt;
      r_sample       <= w_sample_nxt;
      r_sample_ch    <= w_sample_ch_nxt;
      r_sync_mask    <= (w_state_nxt == ST_RUN);
      r_sample_valid <= w_sample_valid_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_err_sep      <= w_err_sep_nxt;
      r_err_short    <= w_err_short_nxt;
      r_err_overrun  <= w_err_overrun_nxt;
    end
  end

  assign o_sync_mask    = r_sync_mask;
  assign o_user         = r_user;
  assign o_sample       = r_sample;
  assign o_sample_ch    = r_sample_ch;
  assign o_sample_valid = r_sample_valid;
  assign o_frame_done   = r_frame_done;
  assign o_err_sep      = r_err_sep;
  assign o_err_short    = r_err_short;
  assign o_err_overrun  = r_err_overrun;

endmodule
